vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Pixel-timing generator directly upstream of the sprite/background renderers.
- Produces DrawX/DrawY scan coordinates, the active-video qualifier `blank`, and the hs/vs sync pulses for a 640x480@60 Hz display.
- Renderers register RGB one vga_clk after sampling DrawX/DrawY/blank. hs/vs therefore leave this block through a configurable delay line so they stay aligned with the renderer's RGB output.

Parameters:
H_VISIBLE, 640, active pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width (clocks)
H_BP, 48, horizontal back porch (clocks)
V_VISIBLE, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_DELAY, 1, pipeline stages on hs/vs (legal range 0..4)

Ports:
vga_clk  in  1  pixel clock, 25 MHz nominal
reset  in  1  asynchronous, active-high reset
DrawX  out  10  current horizontal count, 0..H_TOTAL-1
DrawY  out  10  current vertical count, 0..V_TOTAL-1
blank  out  1  1 = visible pixel (DrawX<H_VISIBLE and DrawY<V_VISIBLE), 0 = blanking
hs  out  1  horizontal sync, active-low, delayed SYNC_DELAY clocks
vs  out  1  vertical sync, active-low, delayed SYNC_DELAY clocks
line_start  out  1  1-clock pulse when DrawX==0
frame_start  out  1  1-clock pulse when DrawX==0 and DrawY==0
frame_count  out  16  completed-frame counter (optional feature)

Behaviour:
- H_TOTAL = sum of the four H parameters = 800.
- V_TOTAL = sum of the four V parameters = 525.
- Horizontal counter hc is a register and drives DrawX directly.
  - Increments every vga_clk.
  - At H_TOTAL-1 it wraps to 0 and vc increments.
- Vertical counter vc is a register and drives DrawY directly.
  - At V_TOTAL-1, coincident with hc at H_TOTAL-1, both wrap to 0 on the same edge.
- blank, line_start and frame_start are combinational decodes of hc/vc, so they align with DrawX/DrawY.
  - All three are forced to 0 while reset is asserted.
- Raw sync decodes:
  - hs_raw = 0 when H_VISIBLE+H_FP <= hc < H_VISIBLE+H_FP+H_SYNC (656..751 at defaults), else 1.
  - vs_raw = 0 when V_VISIBLE+V_FP <= vc < V_VISIBLE+V_FP+V_SYNC (490..491), else 1.
- hs/vs = hs_raw/vs_raw passed through SYNC_DELAY flops.
  - SYNC_DELAY=0 gives a direct combinational decode.
  - With default 1, the sync edges coincide with the RGB register edge of the downstream renderer.
- Reset (asynchronous assert, synchronous release by vga_clk):
  - hc=0, vc=0.
  - Every hs/vs delay stage = 1; hs=1, vs=1.
  - blank=0, line_start=0, frame_start=0, frame_count=0.
- First vga_clk edge after reset release: counters are still (0,0), so frame_start, line_start and blank are all 1 during that cycle.
- Reset asserted mid-frame: all outputs return to reset values immediately without waiting for a clock. No partial sync pulse is stretched: delay stages are cleared to 1.
- A full frame is 420000 clocks.
  - Exactly 307200 clocks per frame have blank=1.
  - hs low for 96 clocks per line.
  - vs low for 1600 consecutive clocks per frame.
- Counters never reach H_TOTAL or V_TOTAL; DrawX is never 800 and DrawY is never 525.

Optional Feature:
VGA_FRAME_COUNT_EN
- Defined:
  - frame_count increments by 1 on the edge where hc and vc both wrap to 0.
  - Wraps from 65535 to 0.
  - Reset value 0.
  - Usable by downstream blocks for sprite animation timing.
- Undefined:
  - frame_count is tied to 16'h0000 and no counter register is synthesised.

Test Plan:
- Hold reset 5 clocks mid-count -> during reset hs=1, vs=1, blank=0, DrawX=0, DrawY=0. On first edge after release, frame_start=1, line_start=1, blank=1.
- Run 1 line with SYNC_DELAY=1 -> hs falls 1 clock after DrawX becomes 656 and rises 1 clock after DrawX becomes 752. blank falls when DrawX becomes 640. DrawX goes 799->0 and DrawY goes 0->1.
- Run 1 full frame -> frame_start pulses exactly once per 420000 clocks. blank=1 count is 307200. vs low for 1600 clocks, starting 1 clock after DrawY becomes 490 with DrawX=0.
- Re-elaborate with SYNC_DELAY=0, then 3 -> hs low exactly at DrawX 656..751 (0 delay), then at DrawX 659..754 (3 delay, with wrap to next-line timing checked).
- Assert reset at DrawX=700, DrawY=491 (inside both syncs) -> hs and vs go to 1 without a clock edge. After release, the next vs pulse arrives only at DrawY=490 of the following frame.
- Define VGA_FRAME_COUNT_EN and force the count to 65535 via 65535 frames or a backdoor -> next frame wrap gives frame_count=0. Without the macro, frame_count stays 0 over 3 frames.

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// -----------------------------------------------------------------------------
// vga_timing_gen_if
// Bundle of scan-timing signals leaving the VGA timing generator.
//   DrawX[9:0]        current horizontal count
//   DrawY[9:0]        current vertical count
//   blank             1 = visible pixel, 0 = blanking interval
//   hs, vs            active-low syncs, delayed to line up with renderer RGB
//   line_start        1-clock pulse at DrawX==0
//   frame_start       1-clock pulse at DrawX==0, DrawY==0
//   frame_count[15:0] completed-frame counter (zero unless enabled)
// Modports: master = the timing generator, slave = renderers/consumers.
// -----------------------------------------------------------------------------
interface vga_timing_gen_if;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        blank;
    logic        hs;
    logic        vs;
    logic        line_start;
    logic        frame_start;
    logic [15:0] frame_count;

    modport master (
        output DrawX, DrawY, blank, hs, vs, line_start, frame_start, frame_count
    );

    modport slave (
        input DrawX, DrawY, blank, hs, vs, line_start, frame_start, frame_count
    );
endinterface

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Pixel-timing generator for a 640x480@60 Hz raster (geometry parameterised).
// Drives scan coordinates, the active-video qualifier and delayed sync pulses
// to the sprite/background renderers.
//
// Ports:
//   vga_clk  in   pixel clock (25 MHz nominal)
//   reset    in   asynchronous, active-high reset
//   vga      master modport of vga_timing_gen_if (all timing outputs)
//
// Parameters:
//   H_VISIBLE/H_FP/H_SYNC/H_BP  horizontal geometry in clocks
//   V_VISIBLE/V_FP/V_SYNC/V_BP  vertical geometry in lines
//   SYNC_DELAY                  flop stages on hs/vs, legal range 0..4
//
// Build option:
//   VGA_FRAME_COUNT_EN  when defined, frame_count counts completed frames
//                       (wrapping at 16 bits); otherwise it is tied to zero.
// -----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SYNC_DELAY = 1
) (
    input  logic           vga_clk,
    input  logic           reset,
    vga_timing_gen_if.master vga
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT    = 10'(H_VISIBLE);
    localparam logic [9:0] V_ACT    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

    logic [9:0] hc;
    logic [9:0] vc;
    logic       hs_raw;
    logic       vs_raw;
    logic       frame_wrap;

    // Last clock of the last line: both counters wrap together on this edge.
    assign frame_wrap = (hc == H_LAST) && (vc == V_LAST);

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            hc <= '0;
            vc <= '0;
        end else if (hc == H_LAST) begin
            hc <= '0;
            vc <= (vc == V_LAST) ? 10'd0 : vc + 10'd1;
        end else begin
            hc <= hc + 10'd1;
        end
    end

    assign vga.DrawX = hc;
    assign vga.DrawY = vc;

    // Decodes are gated by reset so consumers see a quiet bus while held.
    assign vga.blank       = !reset && (hc < H_ACT) && (vc < V_ACT);
    assign vga.line_start  = !reset && (hc == 10'd0);
    assign vga.frame_start = !reset && (hc == 10'd0) && (vc == 10'd0);

    assign hs_raw = !((hc >= HS_START) && (hc < HS_END));
    assign vs_raw = !((vc >= VS_START) && (vc < VS_END));

    // Sync delay line. Stages reset to the inactive level so that a reset in
    // the middle of a pulse ends it at once instead of draining it out.
    generate
        if (SYNC_DELAY == 0) begin : g_no_delay
            assign vga.hs = hs_raw;
            assign vga.vs = vs_raw;
        end else begin : g_delay
            logic [SYNC_DELAY-1:0] hs_pipe;
            logic [SYNC_DELAY-1:0] vs_pipe;

            always_ff @(posedge vga_clk or posedge reset) begin
                if (reset) begin
                    hs_pipe <= '1;
                    vs_pipe <= '1;
                end else begin
                    hs_pipe[0] <= hs_raw;
                    vs_pipe[0] <= vs_raw;
                    for (int i = 1; i < SYNC_DELAY; i++) begin
                        hs_pipe[i] <= hs_pipe[i-1];
                        vs_pipe[i] <= vs_pipe[i-1];
                    end
                end
            end

            assign vga.hs = hs_pipe[SYNC_DELAY-1];
            assign vga.vs = vs_pipe[SYNC_DELAY-1];
        end
    endgenerate

`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] frame_cnt;

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (frame_wrap) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

    assign vga.frame_count = frame_cnt;
`else
    logic unused_wrap;
    assign unused_wrap     = frame_wrap;
    assign vga.frame_count = 16'h0000;
`endif

endmodule
